// File: rtl/exit_park_if.sv
// ---------------------------------------------------------------------------
// exit_park_if
// Bus bundle between the exit-side parking controller and its environment.
//   park_valid/park_slot : entry allocator reports a car taking a slot
//   exit_req/exit_slot   : driver at the exit asks to release a slot
//   time_tick            : timebase pulse for the per-slot duration counters
//   parking_capacity     : occupancy bitmap (bit i = slot i occupied)
//   free_count/lot_full  : derived occupancy summary
//   exit_busy            : exit FSM is handling a request
//   exit_ok/exit_err     : one-cycle result pulses of an exit request
//   fee_amount           : fee of the last accepted exit
//   gate_open            : exit barrier drive
// master = environment side, slave = exit_park controller side.
// ---------------------------------------------------------------------------
interface exit_park_if;
    logic        park_valid;
    logic [2:0]  park_slot;
    logic        exit_req;
    logic [2:0]  exit_slot;
    logic        time_tick;
    logic [7:0]  parking_capacity;
    logic [3:0]  free_count;
    logic        lot_full;
    logic        exit_busy;
    logic        exit_ok;
    logic        exit_err;
    logic [11:0] fee_amount;
    logic        gate_open;

    modport master (
        output park_valid, park_slot, exit_req, exit_slot, time_tick,
        input  parking_capacity, free_count, lot_full, exit_busy,
               exit_ok, exit_err, fee_amount, gate_open
    );

    modport slave (
        input  park_valid, park_slot, exit_req, exit_slot, time_tick,
        output parking_capacity, free_count, lot_full, exit_busy,
               exit_ok, exit_err, fee_amount, gate_open
    );
endinterface

// File: rtl/exit_park.sv
// ---------------------------------------------------------------------------
// exit_park
// Exit-side controller of the 8-slot parking lot. Owns the occupancy bitmap,
// keeps an 8-bit saturating duration counter per slot, validates exit
// requests, computes the fee (duration x RATE) and holds the exit gate open
// for GATE_CYCLES cycles after an accepted exit.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : exit_park_if.slave (park path, exit path, status outputs)
// ---------------------------------------------------------------------------
module exit_park #(
    parameter int unsigned GATE_CYCLES = 4,
    parameter int unsigned RATE        = 2
) (
    input  logic        clk,
    input  logic        rst,
    exit_park_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GATE  = 2'd2
    } state_t;

    localparam logic [3:0]  GATE_LOAD = 4'(GATE_CYCLES);
    localparam logic [11:0] RATE_W    = 12'(RATE);

    state_t      state_q;
    logic [2:0]  slot_q;
    logic [3:0]  timer_q;
    logic        exit_ok_q;
    logic        exit_err_q;
    logic        gate_q;
    logic [11:0] fee_q;

    logic [7:0]  cap_q;
    logic [7:0]  cap_d;
    logic [7:0]  dur_q [8];
    logic [7:0]  dur_d [8];

    logic        chk_clr_s;
    logic [7:0]  clr_s;
    logic [7:0]  set_s;
    logic [11:0] fee_prod_s;

    // Number of set bits in an 8-bit vector.
    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Fee from the counter value before any same-cycle tick; 255*15 fits 12 bits.
    assign fee_prod_s = {4'd0, dur_q[slot_q]} * RATE_W;
    assign chk_clr_s  = (state_q == ST_CHECK) && cap_q[slot_q];

    // Next bitmap and counters: exit clear first, then park set, else tick.
    always_comb begin
        clr_s = 8'd0;
        set_s = 8'd0;
        cap_d = cap_q;
        for (int i = 0; i < 8; i++) begin
            dur_d[i] = dur_q[i];
        end
        for (int i = 0; i < 8; i++) begin
            clr_s[i] = chk_clr_s && (slot_q == 3'(i));
            // A park to a slot being cleared this cycle is honoured.
            set_s[i] = bus.park_valid && (bus.park_slot == 3'(i)) && (!cap_q[i] || clr_s[i]);
            if (set_s[i]) begin
                cap_d[i] = 1'b1;
            end else if (clr_s[i]) begin
                cap_d[i] = 1'b0;
            end else begin
                cap_d[i] = cap_q[i];
            end
            if (set_s[i] || clr_s[i]) begin
                dur_d[i] = 8'd0;
            end else if (bus.time_tick && cap_q[i] && (dur_q[i] != 8'hFF)) begin
                dur_d[i] = dur_q[i] + 8'd1;
            end else begin
                dur_d[i] = dur_q[i];
            end
        end
    end

    // Occupancy bitmap and duration counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                dur_q[i] <= 8'd0;
            end
        end else begin
            cap_q <= cap_d;
            for (int i = 0; i < 8; i++) begin
                dur_q[i] <= dur_d[i];
            end
        end
    end

    // Exit FSM with registered result pulses, fee and gate drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_q     <= 3'd0;
            timer_q    <= 4'd0;
            exit_ok_q  <= 1'b0;
            exit_err_q <= 1'b0;
            gate_q     <= 1'b0;
            fee_q      <= 12'd0;
        end else begin
            exit_ok_q  <= 1'b0;
            exit_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.exit_req) begin
                        slot_q  <= bus.exit_slot;
                        state_q <= ST_CHECK;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (cap_q[slot_q]) begin
                        fee_q     <= fee_prod_s;
                        exit_ok_q <= 1'b1;
                        gate_q    <= 1'b1;
                        timer_q   <= GATE_LOAD;
                        state_q   <= ST_GATE;
                    end else begin
                        exit_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_GATE: begin
                    // Timer counts GATE_CYCLES..1; leaving on 1 gives GATE_CYCLES open cycles.
                    if (timer_q <= 4'd1) begin
                        timer_q <= 4'd0;
                        gate_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q - 4'd1;
                    end
                end
                default: begin
                    timer_q <= 4'd0;
                    gate_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.parking_capacity = cap_q;
    assign bus.free_count       = 4'd8 - count_ones(cap_q);
    assign bus.lot_full         = &cap_q;
    assign bus.exit_busy        = (state_q != ST_IDLE);
    assign bus.exit_ok          = exit_ok_q;
    assign bus.exit_err         = exit_err_q;
    assign bus.fee_amount       = fee_q;
    assign bus.gate_open        = gate_q;

endmodule

// File: tb/tb_exit_park.sv
// ---------------------------------------------------------------------------
// tb_exit_park
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a behavioural lot model (occupancy array, durations, fee,
// exit-in-progress bookkeeping).
// ---------------------------------------------------------------------------
module tb_exit_park;
    localparam int G = 4;
    localparam int R = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exit_park_if bus();

    exit_park #(.GATE_CYCLES(G), .RATE(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model state.
    bit m_occ [8];
    int m_dur [8];
    int m_fee;
    bit m_chk;
    int m_slot;
    int m_gate;
    bit m_ok;
    bit m_err;

    task automatic check_val(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_occ[i] = 1'b0;
            m_dur[i] = 0;
        end
        m_fee = 0; m_chk = 1'b0; m_slot = 0; m_gate = 0; m_ok = 1'b0; m_err = 1'b0;
    endtask

    // One clock edge of lot behaviour.
    task automatic model_step(input bit pv, input int ps, input bit er, input int es, input bit tk);
        int cleared;
        cleared = -1;
        m_ok = 1'b0;
        m_err = 1'b0;
        if (m_chk) begin
            m_chk = 1'b0;
            if (m_occ[m_slot]) begin
                m_fee = m_dur[m_slot] * R;
                m_ok = 1'b1;
                m_gate = G;
                cleared = m_slot;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_gate > 0) begin
            m_gate--;
        end else if (er) begin
            m_chk = 1'b1;
            m_slot = es;
        end
        if (tk) begin
            for (int i = 0; i < 8; i++)
                if (m_occ[i] && m_dur[i] < 255) m_dur[i]++;
        end
        if (cleared >= 0) begin
            m_occ[cleared] = 1'b0;
            m_dur[cleared] = 0;
        end
        if (pv && !m_occ[ps]) begin
            m_occ[ps] = 1'b1;
            m_dur[ps] = 0;
        end
    endtask

    task automatic check_all();
        int cap;
        int used;
        cap = 0;
        used = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_occ[i]) begin
                cap += (1 << i);
                used++;
            end
        end
        check_val("capacity",   int'(bus.parking_capacity), cap);
        check_val("free_count", int'(bus.free_count), 8 - used);
        check_val("lot_full",   int'(bus.lot_full), (used == 8) ? 1 : 0);
        check_val("exit_busy",  int'(bus.exit_busy), (m_chk || m_gate > 0) ? 1 : 0);
        check_val("exit_ok",    int'(bus.exit_ok), int'(m_ok));
        check_val("exit_err",   int'(bus.exit_err), int'(m_err));
        check_val("fee_amount", int'(bus.fee_amount), m_fee);
        check_val("gate_open",  int'(bus.gate_open), (m_gate > 0) ? 1 : 0);
    endtask

    // Drive one cycle of inputs (called at a negedge), advance model, check.
    task automatic cycle(input bit pv, input int ps, input bit er, input int es, input bit tk);
        bus.park_valid = pv;
        bus.park_slot  = 3'(ps);
        bus.exit_req   = er;
        bus.exit_slot  = 3'(es);
        bus.time_tick  = tk;
        @(posedge clk);
        model_step(pv, ps, er, es, tk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    int gcount;
    int okcount;

    initial begin
        bus.park_valid = 1'b0; bus.park_slot = 3'd0;
        bus.exit_req = 1'b0;   bus.exit_slot = 3'd0;
        bus.time_tick = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_val("rst_cap",  int'(bus.parking_capacity), 0);
        check_val("rst_fee",  int'(bus.fee_amount), 0);
        check_val("rst_gate", int'(bus.gate_open), 0);
        check_val("rst_busy", int'(bus.exit_busy), 0);
        rst = 1'b0;

        // Park slots 5 and 7.
        cycle(1'b1, 5, 1'b0, 0, 1'b0);
        cycle(1'b1, 7, 1'b0, 0, 1'b0);
        check_val("park57_cap",  int'(bus.parking_capacity), 8'hA0);
        check_val("park57_free", int'(bus.free_count), 6);

        // 10 ticks, then exit slot 5: fee 20, gate open 4 cycles.
        for (int k = 0; k < 10; k++) cycle(1'b0, 0, 1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b1, 5, 1'b0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check_val("exit5_ok",  int'(bus.exit_ok), 1);
        check_val("exit5_fee", int'(bus.fee_amount), 20);
        gcount = int'(bus.gate_open);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b0, 0, 1'b0, 0, 1'b0);
            gcount += int'(bus.gate_open);
        end
        check_val("gate_len",  gcount, G);
        check_val("exit5_cap", int'(bus.parking_capacity), 8'h80);

        // Exit of free slot 3 is rejected.
        cycle(1'b0, 0, 1'b1, 3, 1'b0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check_val("exit3_err",  int'(bus.exit_err), 1);
        check_val("exit3_gate", int'(bus.gate_open), 0);
        check_val("exit3_fee",  int'(bus.fee_amount), 20);
        idle(2);

        // Fill the lot.
        for (int i = 0; i < 8; i++) cycle(1'b1, i, 1'b0, 0, 1'b0);
        check_val("full_flag", int'(bus.lot_full), 1);
        check_val("full_free", int'(bus.free_count), 0);

        // Repeat park on slot 2 must not reset its duration: fee 5*2.
        for (int k = 0; k < 5; k++) cycle(1'b0, 0, 1'b0, 0, 1'b1);
        cycle(1'b1, 2, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 2, 1'b0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check_val("repark_fee", int'(bus.fee_amount), 10);
        idle(6);

        // Saturation: 300 ticks, exit slot 0 -> 255*2.
        for (int k = 0; k < 300; k++) cycle(1'b0, 0, 1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b1, 0, 1'b0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check_val("sat_fee", int'(bus.fee_amount), 510);
        idle(6);

        // exit_req held high through the gate period: a single exit_ok.
        okcount = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 0, 1'b1, 1, 1'b0);
            okcount += int'(bus.exit_ok);
        end
        check_val("held_req_ok", okcount, 1);
        idle(4);

        // Same-cycle tick, park to the clearing slot: old fee, bit stays set.
        cycle(1'b0, 0, 1'b1, 3, 1'b1);
        cycle(1'b1, 3, 1'b0, 0, 1'b1);
        idle(6);

        // Reset in the middle of the gate period.
        cycle(1'b1, 4, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 4, 1'b0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check_val("pre_rst_gate", int'(bus.gate_open), 1);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_gate", int'(bus.gate_open), 0);
        check_val("mid_rst_cap",  int'(bus.parking_capacity), 0);
        check_val("mid_rst_busy", int'(bus.exit_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, int'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, int'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/exit_park.md
Name: exit_park

Overview:
- Exit-side controller for the 8-slot parking lot; the complement to the entry-side slot allocator.
- Owns the occupancy bitmap `parking_capacity` that the entry allocator reads.
  - The entry side reports each granted slot through a park pulse.
  - Drivers at the exit request release of a slot.
- Validates each exit request, clears the slot, computes the parking fee from a per-slot duration counter, and holds the exit gate open for a fixed time.

Parameters:
- `GATE_CYCLES`, 4, number of clock cycles `gate_open` stays high after a valid exit (legal range 1..15).
- `RATE`, 2, fee units charged per elapsed time tick (legal range 0..15).

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `park_valid`  input  1  one-cycle pulse from the entry allocator: a car took slot `park_slot`.
- `park_slot`  input  3  index of the slot being occupied (0..7).
- `exit_req`  input  1  exit request; sampled only while `exit_busy` = 0.
- `exit_slot`  input  3  slot the exiting car claims to be leaving.
- `time_tick`  input  1  one-cycle timebase pulse that advances the duration counters.
- `parking_capacity`  output  8  occupancy bitmap; bit i = 1 means slot i is occupied. Registered.
- `free_count`  output  4  number of zero bits in `parking_capacity` (0..8).
- `lot_full`  output  1  1 when `parking_capacity` = 8'hFF.
- `exit_busy`  output  1  1 whenever the FSM is not in IDLE.
- `exit_ok`  output  1  one-cycle pulse: exit accepted, `fee_amount` valid.
- `exit_err`  output  1  one-cycle pulse: exit rejected because the slot was not occupied.
- `fee_amount`  output  12  fee for the last accepted exit; holds its value until the next `exit_ok`.
- `gate_open`  output  1  exit barrier drive.

Behaviour:
- Reset (asynchronous, immediate) sets:
  - `parking_capacity` = 0;
  - all eight duration counters = 0;
  - FSM = IDLE;
  - `exit_ok` = 0, `exit_err` = 0, `gate_open` = 0;
  - `fee_amount` = 0.
- Reset asserted mid-operation aborts any exit in progress and closes the gate immediately.
- Derived outputs:
  - `free_count` = 8 − popcount(`parking_capacity`), combinational from the register.
  - `lot_full` = &`parking_capacity`.
- Park path, evaluated every cycle independent of the FSM:
  - `park_valid` with the target bit = 0: set the bit and clear that slot's duration counter.
  - `park_valid` to an already-occupied slot is ignored: bitmap and counter are unchanged.
- Duration counters (8 × 8-bit):
  - On `time_tick`, each occupied slot's counter increments, saturating at 255.
  - Free slots hold 0.
- FSM states: IDLE, CHECK, GATE.
  - IDLE:
    - `exit_req` = 1 latches `exit_slot` into `slot_q` and moves to CHECK.
    - `exit_req` is ignored in every other state; it is not queued.
  - CHECK (exactly one cycle):
    - If `parking_capacity[slot_q]` = 1: clear the bit, zero the counter, and register `fee_amount` = counter × `RATE`.
      - The product is computed in 12 bits; 255 × 15 = 3825 cannot overflow.
      - Pulse `exit_ok` in the following cycle, load the gate timer with `GATE_CYCLES`, and go to GATE.
    - Otherwise: pulse `exit_err` in the following cycle and return to IDLE. `fee_amount` is unchanged.
  - GATE:
    - `gate_open` = 1 and the timer decrements each cycle.
    - When the timer reaches 1, go to IDLE; `gate_open` then deasserts.
    - `gate_open` is high for exactly `GATE_CYCLES` cycles.
- Latency:
  - `exit_req` sampled at edge N → `exit_ok` or `exit_err` high during the cycle after edge N+1.
  - `gate_open` rises together with `exit_ok`.
- Simultaneous events:
  - A `time_tick` in the same cycle as the CHECK clear: the fee uses the pre-increment counter value.
  - A `park_valid` to the same slot in the same cycle as the CHECK clear: the clear applies first, then the set. The bit ends at 1, the counter ends at 0, and `exit_ok` still fires with the old fee.
  - `park_valid` and `time_tick` together: the newly parked slot's counter ends at 0.

Test Plan:
- Reset, then `park_valid` for slots 5 and 7 → `parking_capacity` = 8'b10100000, `free_count` = 6, `lot_full` = 0.
- Slot 5 occupied, 10 `time_tick` pulses, `exit_req` with `exit_slot` = 5, `RATE` = 2:
  - `exit_ok` pulses 2 cycles after the request, `fee_amount` = 20;
  - `parking_capacity` = 8'b10000000;
  - `gate_open` high for exactly 4 cycles.
- `exit_req` for free slot 3 → `exit_err` pulse, `gate_open` stays 0, bitmap and `fee_amount` unchanged.
- Park all 8 slots → `lot_full` = 1, `free_count` = 0. A repeat `park_valid` to slot 2 leaves its counter unchanged. 300 ticks followed by an exit of slot 0 → `fee_amount` = 510 (saturated at 255 × 2).
- `exit_req` held high during GATE → no second `exit_ok`. Asserting `rst` mid-GATE → `gate_open` drops without waiting for a clock, bitmap = 0, FSM back in IDLE.
